// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and byte classification for the PS/2 scan sequencer.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Bytes that follow the Pause lead-in byte before the sequence completes.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_GAP
  } state_t;

  // Keyboard status and acknowledge bytes that never form part of a key event.
  function automatic logic is_status_byte(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_scan_sequencer.sv
// Drains the ps2_keyboard FIFO and folds E0/F0/E1 prefixes into single key events.
// Optional build macro PS2_REPEAT_FILTER_EN suppresses typematic repeat makes.
module ps2_scan_sequencer
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_brk,
  output logic             held_valid,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             err_ovf
);

  state_t           state_q, state_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             evt_valid_q, evt_valid_d;
  logic [7:0]       evt_code_q, evt_code_d;
  logic             evt_ext_q, evt_ext_d;
  logic             evt_brk_q, evt_brk_d;
  logic             held_valid_q, held_valid_d;
  logic [8:0]       held_code_q, held_code_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             err_ovf_q, err_ovf_d;
  logic             ext_seen_q, ext_seen_d;
  logic             brk_seen_q, brk_seen_d;
  logic [2:0]       pause_cnt_q, pause_cnt_d;

  logic             emit;
  logic             emit_pause;
  logic             emit_ext;
  logic             emit_brk;
  logic [7:0]       emit_code;
  logic             repeat_hit;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= S_IDLE;
      nextdata_n_q  <= 1'b1;
      evt_valid_q   <= 1'b0;
      evt_code_q    <= 8'h00;
      evt_ext_q     <= 1'b0;
      evt_brk_q     <= 1'b0;
      held_valid_q  <= 1'b0;
      held_code_q   <= 9'h000;
      press_count_q <= '0;
      err_ovf_q     <= 1'b0;
      ext_seen_q    <= 1'b0;
      brk_seen_q    <= 1'b0;
      pause_cnt_q   <= 3'd0;
    end else begin
      state_q       <= state_d;
      nextdata_n_q  <= nextdata_n_d;
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      evt_ext_q     <= evt_ext_d;
      evt_brk_q     <= evt_brk_d;
      held_valid_q  <= held_valid_d;
      held_code_q   <= held_code_d;
      press_count_q <= press_count_d;
      err_ovf_q     <= err_ovf_d;
      ext_seen_q    <= ext_seen_d;
      brk_seen_q    <= brk_seen_d;
      pause_cnt_q   <= pause_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    nextdata_n_d  = 1'b1;
    evt_valid_d   = evt_valid_q;
    evt_code_d    = evt_code_q;
    evt_ext_d     = evt_ext_q;
    evt_brk_d     = evt_brk_q;
    held_valid_d  = held_valid_q;
    held_code_d   = held_code_q;
    press_count_d = press_count_q;
    err_ovf_d     = err_ovf_q | overflow;
    ext_seen_d    = ext_seen_q;
    brk_seen_d    = brk_seen_q;
    pause_cnt_d   = pause_cnt_q;
    emit          = 1'b0;
    emit_pause    = 1'b0;
    emit_ext      = 1'b0;
    emit_brk      = 1'b0;
    emit_code     = data;
    repeat_hit    = 1'b0;

    if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // Overflow means bytes were lost, so any partial prefix is meaningless.
        if (overflow) begin
          ext_seen_d  = 1'b0;
          brk_seen_d  = 1'b0;
          pause_cnt_d = 3'd0;
        end
        if (ready && (!evt_valid_q || evt_ready)) begin
          state_d      = S_ACK;
          nextdata_n_d = 1'b0;
          if (pause_cnt_d != 3'd0) begin
            pause_cnt_d = pause_cnt_d - 3'd1;
            if (pause_cnt_d == 3'd0) begin
              emit       = 1'b1;
              emit_pause = 1'b1;
              emit_code  = PS2_PAUSE;
            end
          end else if (data == PS2_PAUSE) begin
            pause_cnt_d = PAUSE_TAIL;
            ext_seen_d  = 1'b0;
            brk_seen_d  = 1'b0;
          end else if (data == PS2_EXT) begin
            ext_seen_d = 1'b1;
          end else if (data == PS2_BRK) begin
            brk_seen_d = 1'b1;
          end else if (is_status_byte(data)) begin
            ext_seen_d = 1'b0;
            brk_seen_d = 1'b0;
          end else begin
            emit       = 1'b1;
            emit_ext   = ext_seen_d;
            emit_brk   = brk_seen_d;
            ext_seen_d = 1'b0;
            brk_seen_d = 1'b0;
          end
        end
      end
      S_ACK:   state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef PS2_REPEAT_FILTER_EN
    repeat_hit = !emit_pause && !emit_brk && held_valid_q &&
                 (held_code_q == {emit_ext, emit_code});
`endif

    // A newly classified event overrides any event accepted in this same cycle.
    if (emit && !repeat_hit) begin
      evt_valid_d = 1'b1;
      evt_code_d  = emit_code;
      evt_ext_d   = emit_ext;
      evt_brk_d   = emit_brk;
      if (!emit_brk) begin
        press_count_d = press_count_q + CNT_W'(1);
        if (!emit_pause) begin
          held_valid_d = 1'b1;
          held_code_d  = {emit_ext, emit_code};
        end
      end else if (held_valid_q && (held_code_q == {emit_ext, emit_code})) begin
        held_valid_d = 1'b0;
      end
    end
  end

  assign nextdata_n  = nextdata_n_q;
  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_code_q;
  assign evt_ext     = evt_ext_q;
  assign evt_brk     = evt_brk_q;
  assign held_valid  = held_valid_q;
  assign held_code   = held_code_q;
  assign press_count = press_count_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Scoreboard bench for ps2_scan_sequencer: FIFO feeder, event-level reference model, monitor.
module tb_ps2_scan_sequencer;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       held_valid;
  logic [8:0] held_code;
  logic [7:0] press_count;
  logic       err_ovf;

  ps2_scan_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk),
    .held_valid(held_valid), .held_code(held_code), .press_count(press_count),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       hv;
    logic [8:0] hc;
    logic [7:0] cnt;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] fifo[$];
  int         errors = 0;
  int         checks = 0;
  int         pulse_count = 0;
  int         pushed = 0;
  int         rdy_mode = 1;

  // Reference model state, expressed at the level of key events.
  bit         m_ext, m_brk;
  int         m_pause_left;
  bit         m_hv;
  bit  [8:0]  m_hc;
  bit  [7:0]  m_cnt;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_pause_left = 0;
    m_hv = 0; m_hc = 0; m_cnt = 0;
  endtask

  task automatic model_emit(input bit [7:0] code, input bit ext, input bit brk, input bit is_pause);
    exp_t e;
    if (!brk && !is_pause) begin
`ifdef PS2_REPEAT_FILTER_EN
      if (m_hv && m_hc == {ext, code}) return;
`endif
      m_cnt = m_cnt + 8'd1;
      m_hv = 1;
      m_hc = {ext, code};
    end else if (is_pause) begin
      m_cnt = m_cnt + 8'd1;
    end else if (m_hv && m_hc == {ext, code}) begin
      m_hv = 0;
    end
    e.code = code; e.ext = ext; e.brk = brk;
    e.hv = m_hv; e.hc = m_hc; e.cnt = m_cnt;
    expq.push_back(e);
  endtask

  task automatic model_byte(input bit [7:0] b);
    if (m_pause_left > 0) begin
      m_pause_left--;
      if (m_pause_left == 0) model_emit(8'hE1, 0, 0, 1);
    end else if (b == 8'hE1) begin
      m_pause_left = 7; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      model_emit(b, m_ext, m_brk, 0);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    model_byte(b);
    fifo.push_back(b);
    pushed++;
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (fifo.size() == 0 && expq.size() == 0) begin
        done = 1;
        break;
      end
    end
    repeat (8) @(posedge clk);
    #1;
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL %s drain: timeout, fifo=%0d pending_events=%0d required 0/0",
               name, fifo.size(), expq.size());
    end
  endtask

  task automatic check_phase(input string name);
    check_output({name, " press_count"}, 32'(press_count), 32'(m_cnt));
    check_output({name, " held_valid"},  32'(held_valid),  32'(m_hv));
    check_output({name, " held_code"},   32'(held_code),   32'(m_hc));
    check_output({name, " pop_pulses"},  32'(pulse_count), 32'(pushed));
  endtask

  // FIFO feeder: pops the head byte after each nextdata_n low cycle, drives evt_ready.
  initial begin
    bit ack;
    ready = 0; data = 8'h00; evt_ready = 1;
    forever begin
      @(negedge clk);
      ack = clrn && !nextdata_n;
      if (ack) pulse_count++;
      @(posedge clk);
      #1;
      if (ack && fifo.size() > 0) void'(fifo.pop_front());
      ready = (fifo.size() != 0);
      data  = ready ? fifo[0] : 8'h00;
      case (rdy_mode)
        0:       evt_ready = 1'b0;
        1:       evt_ready = 1'b1;
        default: evt_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every accepted event is compared with the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (clrn && evt_valid && evt_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("[TB] FAIL event: unexpected code=%0h ext=%0b brk=%0b, none required",
                   evt_code, evt_ext, evt_brk);
        end else begin
          e = expq.pop_front();
          if (evt_code !== e.code || evt_ext !== e.ext || evt_brk !== e.brk ||
              held_valid !== e.hv || held_code !== e.hc || press_count !== e.cnt) begin
            errors++;
            $display("[TB] FAIL event: got code=%0h ext=%0b brk=%0b hv=%0b hc=%0h cnt=%0d required code=%0h ext=%0b brk=%0b hv=%0b hc=%0h cnt=%0d",
                     evt_code, evt_ext, evt_brk, held_valid, held_code, press_count,
                     e.code, e.ext, e.brk, e.hv, e.hc, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] seq[$];
    logic [7:0] pal[$];
    logic [7:0] prev, code;
    int         pulses0;
    bit         seen;

    clrn = 0; overflow = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset nextdata_n",  32'(nextdata_n),  32'd1);
    check_output("reset evt_valid",   32'(evt_valid),   32'd0);
    check_output("reset held_valid",  32'(held_valid),  32'd0);
    check_output("reset press_count", 32'(press_count), 32'd0);
    check_output("reset err_ovf",     32'(err_ovf),     32'd0);
    #3 clrn = 1;

    $display("[TB] make/break 1C");
    seq = '{8'h1C, 8'hF0, 8'h1C};
    foreach (seq[i]) apply_stimulus(seq[i]);
    wait_drain("makebreak"); check_phase("makebreak");

    $display("[TB] extended break 75");
    seq = '{8'hE0, 8'hF0, 8'h75};
    foreach (seq[i]) apply_stimulus(seq[i]);
    wait_drain("extbreak"); check_phase("extbreak");

    $display("[TB] pause sequence");
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (seq[i]) apply_stimulus(seq[i]);
    wait_drain("pause"); check_phase("pause");

    $display("[TB] typematic repeat");
    seq = '{8'h1C, 8'h1C, 8'h1C};
    foreach (seq[i]) apply_stimulus(seq[i]);
    wait_drain("repeat"); check_phase("repeat");

    $display("[TB] consumer stall");
    pulses0 = pulse_count;
    rdy_mode = 0;
    @(posedge clk);
    seq = '{8'h1C, 8'h32};
    foreach (seq[i]) apply_stimulus(seq[i]);
    repeat (25) @(posedge clk);
    #1;
    check_output("stall evt_valid",   32'(evt_valid),             32'd1);
    check_output("stall evt_code",    32'(evt_code),              32'h1C);
    check_output("stall nextdata_n",  32'(nextdata_n),            32'd1);
    check_output("stall pop_pulses",  32'(pulse_count - pulses0), 32'd1);
    rdy_mode = 1;
    wait_drain("stall"); check_phase("stall");

    $display("[TB] press_count wrap");
    prev = 8'h32;
    for (int i = 0; i < 256; i++) begin
      do code = 8'($urandom_range(8'h01, 8'h7F)); while (code == prev);
      apply_stimulus(code);
      prev = code;
    end
    wait_drain("wrap"); check_phase("wrap");

    $display("[TB] overflow");
    apply_stimulus(8'hE0);
    wait_drain("ovf_prefix");
    @(posedge clk); #1 overflow = 1;
    @(posedge clk); #1 overflow = 0;
    m_ext = 0; m_brk = 0; m_pause_left = 0;
    check_output("ovf err_ovf set", 32'(err_ovf), 32'd1);
    apply_stimulus(8'h29);
    wait_drain("ovf"); check_phase("ovf");
    check_output("ovf err_ovf sticky", 32'(err_ovf), 32'd1);

    $display("[TB] randomized traffic");
    rdy_mode = 2;
    pal = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h75, 8'h6B, 8'h14, 8'h77};
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 15))
        0, 1:    apply_stimulus(8'hE0);
        2, 3, 4: apply_stimulus(8'hF0);
        5:       apply_stimulus(8'hE1);
        6:       apply_stimulus(8'hFA);
        default: apply_stimulus(pal[$urandom_range(0, 7)]);
      endcase
    end
    wait_drain("random");
    rdy_mode = 1;
    repeat (4) @(posedge clk);
    #1;
    check_phase("random");

    $display("[TB] reset during break prefix");
    apply_stimulus(8'h1C);
    wait_drain("pre_reset");
    fifo.push_back(8'hF0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!nextdata_n) begin
        seen = 1;
        break;
      end
    end
    check_output("reset pop seen", 32'(seen), 32'd1);
    clrn = 0;
    #1;
    check_output("midreset nextdata_n",  32'(nextdata_n),  32'd1);
    check_output("midreset evt_valid",   32'(evt_valid),   32'd0);
    check_output("midreset evt_code",    32'(evt_code),    32'd0);
    check_output("midreset held_valid",  32'(held_valid),  32'd0);
    check_output("midreset held_code",   32'(held_code),   32'd0);
    check_output("midreset press_count", 32'(press_count), 32'd0);
    check_output("midreset err_ovf",     32'(err_ovf),     32'd0);
    fifo.delete();
    expq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    pulse_count = 0; pushed = 0;
    clrn = 1;
    apply_stimulus(8'h1C);
    wait_drain("post_reset"); check_phase("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_sequencer.md
Name: ps2_scan_sequencer

Overview:
Controller that drains the ps2_keyboard receiver FIFO over its ready/nextdata_n handshake and assembles raw scan-code bytes into key events.
- Folds the E0 (extended) and F0 (break) prefixes into event flags.
- Collapses the 8-byte Pause sequence into a single event.
- Drops keyboard status bytes.
- Tracks the currently held key and a make-event counter.
- Sits between ps2_keyboard and display/consumer logic, replacing ad-hoc prefix handling in top levels.

Parameters:
CNT_W, 8, width of press_count (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock; the only clock
clrn  in  1  asynchronous active-low reset
ready  in  1  receiver FIFO non-empty; data valid while high
data  in  8  receiver FIFO head byte
overflow  in  1  receiver FIFO overflow flag
nextdata_n  out  1  active-low pop strobe to receiver, one cycle per byte
evt_valid  out  1  key event available
evt_ready  in  1  consumer accepts event (transfer when evt_valid & evt_ready)
evt_code  out  8  scan code of event
evt_ext  out  1  event was E0-prefixed
evt_brk  out  1  event is a release (F0-prefixed)
held_valid  out  1  a key is currently held
held_code  out  9  {ext, code} of held key
press_count  out  CNT_W  number of emitted make events
err_ovf  out  1  sticky: receiver overflow observed

Behaviour:
- Reset (clrn low, asynchronous): nextdata_n=1, evt_valid=0, evt_code=0, evt_ext=0, evt_brk=0, held_valid=0, held_code=0, press_count=0, err_ovf=0, ext_seen=0, brk_seen=0, pause_cnt=0, state=S_IDLE. Reset mid-sequence discards partial prefixes and any pending event.
- States:
  - S_IDLE: consumes a byte when ready=1 and (evt_valid=0 or evt_ready=1), i.e. at most one pending event.
  - S_ACK: nextdata_n=0 for exactly one cycle.
  - S_GAP: nextdata_n=1 for one cycle so the receiver's ready/data can update.
  - Then back to S_IDLE. Throughput is one byte per 3 cycles.
- Byte classification on consume (cycle N):
  - pause_cnt!=0: decrement; on reaching 0, emit code=E1, ext=0, brk=0.
  - E1: pause_cnt<=7; clear ext_seen/brk_seen.
  - E0: ext_seen<=1.
  - F0: brk_seen<=1.
  - AA, FA, EE, FE, FC, 00, FF: dropped; clear both prefix flags.
  - Otherwise: emit {code=data, ext=ext_seen, brk=brk_seen}; clear both flags.
- Emission timing: evt_* are registered at the end of cycle N, so evt_valid is high in N+1, the same cycle nextdata_n is low. evt_valid holds with stable fields until accepted. Acceptance and a new emit in the same cycle: the new event wins and evt_valid stays 1.
- Make event (brk=0): press_count+1 (wraps to 0 after 2^CNT_W-1); held_code<={ext,code}; held_valid<=1.
- Break event: if {ext,code}==held_code and held_valid, held_valid<=0. A non-matching break is still emitted with held unchanged.
- Pause event counts as a make but does not update held.
- overflow: when sampled 1 in any cycle, err_ovf<=1 (sticky until reset); in S_IDLE it also clears the prefix flags and pause_cnt. Byte consumption continues normally.
- ready dropping while in S_ACK/S_GAP: no effect; a byte is popped only once.

Optional Feature:
PS2_REPEAT_FILTER_EN
- Defined: a make whose {ext,code} equals held_code while held_valid=1 (typematic repeat) is popped silently. No event is emitted and press_count does not increment.
- Undefined: every repeat make is emitted and counted.

Decomposition:
- Package ps2_pkg holds:
  - byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1;
  - the status-byte drop list as a function is_status_byte;
  - the state enum {S_IDLE, S_ACK, S_GAP};
  - PAUSE_TAIL=7.
- No sub-module: a single FSM plus registers.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1 -> events (1C,ext0,brk0) then (1C,ext0,brk1); press_count=1; held_valid 1 then 0; each byte gives exactly one nextdata_n low pulse.
- Bytes E0, F0, 75 -> single event code=75, ext=1, brk=1; no events for the prefix bytes.
- Bytes E1,14,77,E1,F0,14,F0,77 -> exactly one event code=E1, ext=0, brk=0; press_count+1.
- Bytes 1C,1C,1C (held) -> with PS2_REPEAT_FILTER_EN: 1 event, press_count=1; without it: 3 events, press_count=3.
- evt_ready=0 with bytes 1C,32 queued -> evt stays 1C with nextdata_n held 1; raise evt_ready -> 32 follows. 256 makes with CNT_W=8 -> press_count wraps to 0.
- overflow pulse after E0, then 29 -> err_ovf=1 sticky, event 29 has ext=0. Assert clrn mid-F0 -> all outputs return to reset values.
